huffman_feed_arbiter: RTL and testbench

HUFFMAN_FEED_ARBITER -- requirements
Module: huffman_feed_arbiter

---
 rtl/huffman_feed_arbiter.sv | 123 ++++++++++++
 tb/tb_huffman_feed_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_feed_arbiter.sv
// rtl/huffman_feed_arbiter.sv - two-requester round-robin byte feeder for a serial Huffman decoder
module huffman_feed_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             dec_data_in,
  output logic             dec_data_valid,
  input  logic             dec_out_valid,
  output logic [1:0]       grant,
  output logic             pkt_done,
  output logic [CNT_W-1:0] sym_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, STALL, GAP} state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       last_q;
  logic [3:0] gap_cnt;
  logic       rr_last;

  logic       sel;
  logic       own_valid;
  logic       take_next;
  logic       idle_take;
  logic       accept;
  logic [7:0] in_data;
  logic       in_last;

  // In IDLE the requester not served last wins a tie.
  assign sel       = (req0_valid && req1_valid) ? ~rr_last : req1_valid;
  assign own_valid = grant[1] ? req1_valid : req0_valid;
  assign idle_take = (state == IDLE) && (req0_valid || req1_valid);
  assign take_next = ((state == SHIFT) && (bit_cnt == 3'd7) && !last_q) || (state == STALL);

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (reset_n) begin
      req0_ready = (idle_take && !sel) || (take_next && own_valid && !grant[1]);
      req1_ready = (idle_take &&  sel) || (take_next && own_valid &&  grant[1]);
    end
  end

  assign accept  = req0_ready || req1_ready;
  assign in_data = req1_ready ? req1_data : req0_data;
  assign in_last = req1_ready ? req1_last : req0_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      shreg          <= 8'h00;
      bit_cnt        <= 3'd0;
      last_q         <= 1'b0;
      gap_cnt        <= 4'd0;
      rr_last        <= 1'b1;
      grant          <= 2'b00;
      dec_data_valid <= 1'b0;
      dec_data_in    <= 1'b0;
      pkt_done       <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (accept) begin
        // The MSB is presented straight from the load so bytes run back to back.
        state          <= SHIFT;
        shreg          <= in_data;
        dec_data_in    <= in_data[7];
        dec_data_valid <= 1'b1;
        bit_cnt        <= 3'd0;
        last_q         <= in_last;
        if (state == IDLE) begin
          grant   <= req1_ready ? 2'b10 : 2'b01;
          rr_last <= req1_ready;
        end
      end else begin
        case (state)
          SHIFT: begin
            if (bit_cnt != 3'd7) begin
              shreg       <= {shreg[6:0], 1'b0};
              dec_data_in <= shreg[6];
              bit_cnt     <= bit_cnt + 3'd1;
              pkt_done    <= last_q && (bit_cnt == 3'd6);
            end else if (last_q) begin
              state          <= GAP;
              grant          <= 2'b00;
              dec_data_valid <= 1'b0;
              dec_data_in    <= 1'b0;
              gap_cnt        <= 4'(GAP_CYCLES - 1);
            end else begin
              state          <= STALL;
              dec_data_valid <= 1'b0;
              dec_data_in    <= 1'b0;
            end
          end
          GAP: begin
            if (gap_cnt == 4'd0) state <= IDLE;
            else                 gap_cnt <= gap_cnt - 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sym_count <= '0;
    else if (dec_out_valid && (sym_count != {CNT_W{1'b1}}))
      sym_count <= sym_count + 1'b1;
  end

endmodule

// File: tb/tb_huffman_feed_arbiter.sv
// tb/tb_huffman_feed_arbiter.sv - randomized scoreboard bench for huffman_feed_arbiter
module tb_huffman_feed_arbiter;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0]  req0_data = 8'h00, req1_data = 8'h00;
  logic        req0_ready, req1_ready;
  logic        dec_data_in, dec_data_valid, pkt_done;
  logic        dec_out_valid = 1'b0;
  logic [1:0]  grant;
  logic [15:0] sym_count;
  logic        b_r0, b_r1, b_din, b_dv, b_pd;
  logic [1:0]  b_grant;
  logic [3:0]  sym_count4;

  huffman_feed_arbiter #(.GAP_CYCLES(GAP), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .dec_data_in(dec_data_in), .dec_data_valid(dec_data_valid), .dec_out_valid(dec_out_valid),
    .grant(grant), .pkt_done(pkt_done), .sym_count(sym_count));

  huffman_feed_arbiter #(.GAP_CYCLES(GAP), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(1'b0), .req0_data(8'h00), .req0_last(1'b0), .req0_ready(b_r0),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_last(1'b0), .req1_ready(b_r1),
    .dec_data_in(b_din), .dec_data_valid(b_dv), .dec_out_valid(dec_out_valid),
    .grant(b_grant), .pkt_done(b_pd), .sym_count(sym_count4));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [8:0]  src0[$];
  logic [8:0]  src1[$];
  int          pv0 = 100, pv1 = 100;
  logic [1:0]  exp_q[$];   // {end_of_packet, bit}
  int          owner_m, last_win, done_cyc, cyc = 0;
  int unsigned cnt16, cnt4;
  logic        hs0 = 1'b0, hs1 = 1'b0;

  task automatic model_reset();
    exp_q.delete();
    owner_m  = -1;
    last_win = 1;
    done_cyc = -100;
    cnt16    = 0;
    cnt4     = 0;
  endtask

  task automatic add_pkt(input int r, input int len, input logic [7:0] first);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = (i == 0) ? first : 8'($urandom);
      if (r == 0) src0.push_back({(i == len - 1), b});
      else        src1.push_back({(i == len - 1), b});
    end
  endtask

  task automatic monitor();
    logic [1:0] e, exp_rdy, exp_grant;
    logic [8:0] byt;
    int         sel;
    cyc++;
    check_eq("sym_count", 32'(sym_count), cnt16);
    check_eq("sym_count4", 32'(sym_count4), cnt4);
    if (dec_out_valid) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt4 < 15) cnt4++;
    end
    exp_grant = (owner_m < 0) ? 2'b00 : ((owner_m == 1) ? 2'b10 : 2'b01);
    check_eq("grant", 32'(grant), 32'(exp_grant));
    check_eq("dec_data_valid", 32'(dec_data_valid), 32'(exp_q.size() > 0));
    if (dec_data_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("dec_data_in", 32'(dec_data_in), 32'(e[0]));
      check_eq("pkt_done", 32'(pkt_done), 32'(e[1]));
      if (e[1]) begin
        owner_m  = -1;
        done_cyc = cyc;
      end
    end else begin
      check_eq("pkt_done_idle", 32'(pkt_done), 0);
      check_eq("dec_data_in_idle", 32'(dec_data_in), 0);
    end
    exp_rdy = 2'b00;
    if (owner_m < 0) begin
      if ((cyc - done_cyc >= GAP + 1) && (req0_valid || req1_valid)) begin
        sel = (req0_valid && req1_valid) ? 1 - last_win : (req1_valid ? 1 : 0);
        exp_rdy = (sel == 1) ? 2'b10 : 2'b01;
      end
    end else if (exp_q.size() == 0) begin
      exp_rdy = (owner_m == 1) ? {req1_valid, 1'b0} : {1'b0, req0_valid};
    end
    check_eq("ready", 32'({req1_ready, req0_ready}), 32'(exp_rdy));
    hs0 = req0_ready && req0_valid;
    hs1 = req1_ready && req1_valid;
    if (hs0 || hs1) begin
      byt = hs1 ? {req1_last, req1_data} : {req0_last, req0_data};
      if (owner_m < 0) begin
        owner_m  = hs1 ? 1 : 0;
        last_win = owner_m;
      end
      for (int i = 7; i >= 0; i--) exp_q.push_back({(i == 0) && byt[8], byt[i]});
    end
  endtask

  task automatic drive();
    if (hs0) void'(src0.pop_front());
    if (hs1) void'(src1.pop_front());
    hs0 = 1'b0;
    hs1 = 1'b0;
    req0_valid = (src0.size() > 0) && (int'($urandom_range(99)) < pv0);
    req1_valid = (src1.size() > 0) && (int'($urandom_range(99)) < pv1);
    if (src0.size() > 0) {req0_last, req0_data} = src0[0];
    if (src1.size() > 0) {req1_last, req1_data} = src1[0];
    dec_out_valid = ($urandom_range(2) == 0);
  endtask

  task automatic step();
    @(negedge clk);
    if (reset_n) monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  initial begin
    bit found;
    model_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    dec_out_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_dvalid", 32'(dec_data_valid), 0);
    check_eq("rst_din", 32'(dec_data_in), 0);
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_pkt_done", 32'(pkt_done), 0);
    check_eq("rst_ready", 32'({req1_ready, req0_ready}), 0);
    check_eq("rst_sym_count", 32'(sym_count), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    src0.push_back({1'b1, 8'h50});
    drive();
    repeat (20) step();

    // both requesters continuously valid with single-byte packets
    for (int i = 0; i < 6; i++) begin
      src0.push_back({1'b1, 8'hAA});
      src1.push_back({1'b1, 8'h55});
    end
    repeat (70) step();

    // two-byte packet back to back, then a stalled packet with req1 waiting
    src0.push_back({1'b0, 8'h5A});
    src0.push_back({1'b1, 8'hA0});
    repeat (30) step();
    src0.push_back({1'b0, 8'hFF});
    src0.push_back({1'b1, 8'h00});
    src1.push_back({1'b1, 8'h33});
    repeat (11) step();
    pv0 = 0;
    repeat (5) step();
    pv0 = 100;
    repeat (30) step();

    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) begin
        pv0 = 30 + int'($urandom_range(70));
        pv1 = 30 + int'($urandom_range(70));
      end
      if (src0.size() < 3) add_pkt(0, 1 + int'($urandom_range(3)), 8'($urandom));
      if (src1.size() < 3) add_pkt(1, 1 + int'($urandom_range(3)), 8'($urandom));
      step();
    end

    // reset in the middle of a byte
    pv0 = 100;
    pv1 = 100;
    add_pkt(0, 3, 8'hC3);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      step();
      if (dec_data_valid && (exp_q.size() % 8 == 5)) found = 1'b1;
    end
    check_eq("reset_point_found", 32'(found), 1);
    #2;
    reset_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_eq("arst_dvalid", 32'(dec_data_valid), 0);
    check_eq("arst_din", 32'(dec_data_in), 0);
    check_eq("arst_grant", 32'(grant), 0);
    check_eq("arst_pkt_done", 32'(pkt_done), 0);
    check_eq("arst_ready", 32'({req1_ready, req0_ready}), 0);
    check_eq("arst_sym_count4", 32'(sym_count4), 0);
    model_reset();
    src0.delete();
    src1.delete();
    src1.push_back({1'b1, 8'h96});
    repeat (2) @(posedge clk);
    #1;
    drive();
    reset_n = 1'b1;
    repeat (30) step();
    check_eq("req1_served", 32'(src1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
